centered_project_parity_polytope_bisect: RTL and testbench
==========================================================

Name: centered_project_parity_polytope_bisect

Overview:
Iterative, variable-degree successor to the pipelined centered parity-polytope projection used by the ADMM-LP check-node update. It accepts one check vector of up to MAX_DEGREE lanes in centered coordinates (u = 2x-1). It box-projects the vector, tests it against the odd-set facet, and if the test fails, finds the facet shift β by bisection over BISECT_ITERS cycles. This block replaces a full-width pipeline with a small time-sequenced datapath for area-limited decoders with irregular check degrees.

Parameters:
TAG_WIDTH, 32, side-band tag carried unchanged from input to output
MAX_DEGREE, 8, number of physical lanes; the largest check degree supported
DATA_WIDTH, 8, signed two's-complement width of each lane, both input and output
IN_FRACTION_WIDTH, 6, fraction bits of data_in; must be less than DATA_WIDTH-1
BISECT_ITERS, 8, number of bisection iterations for β

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
ready_in  in  1  downstream can accept data
valid_in  in  1  input word is present
tag_in  in  TAG_WIDTH  tag for the input word
degree_in  in  clog2(MAX_DEGREE+1)  active lane count d
data_in  in  DATA_WIDTH*MAX_DEGREE  lane i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]; fraction width IN_FRACTION_WIDTH
busy  out  1  a transaction is in flight
ready_out  out  1  block can accept an input
valid_out  out  1  output word is valid
tag_out  out  TAG_WIDTH  tag of the current result
data_out  out  DATA_WIDTH*MAX_DEGREE  result with 0 integer bits (fraction DATA_WIDTH-1)

Behaviour:
- Reset asserted (low): state goes to IDLE; busy=0, valid_out=0, ready_out=0, tag_out=0, data_out=0, all datapath registers cleared. ready_out rises on the first clk edge after reset is released. Reset asserted in any state aborts the in-flight transaction and produces no output.
- Input transfer: valid_in && ready_out at a clk edge. The block captures tag_in, degree_in and data_in in that cycle.
- Output transfer: valid_out && ready_in.
- ready_out = (state==IDLE). busy = (state!=IDLE).
- Degree handling: d is clamped to the range [2, MAX_DEGREE]. Lanes with index d or higher are ignored in all computation, and their output is 0.
- Fixed-point conventions: ONE = 2^IN_FRACTION_WIDTH. Sums use width DATA_WIDTH + clog2(MAX_DEGREE) + 2. β is an unsigned value of width DATA_WIDTH+1 with fraction IN_FRACTION_WIDTH.
- FSM states: IDLE, SIGN, TEST, BISECT, FINAL, OUT.
- IDLE: on input transfer, go to SIGN.
- SIGN:
  - z_i = clip(u_i, -ONE, +ONE).
  - s_i = +1 if z_i > 0, else -1.
  - Register the index m of the minimum |z_i| over active lanes; on a tie, the lowest index wins.
  - Go to TEST.
- TEST:
  - If the count of s_i=+1 is even, negate s_m.
  - Compute g = Σ s_i·z_i and compare it with (d-2)·ONE.
  - If g ≤ (d-2)·ONE, the result is z; go to OUT.
  - Otherwise set lo=0, hi=2·ONE, k=0, and go to BISECT.
- BISECT, one iteration per cycle:
  - mid = (lo+hi)>>1.
  - g = Σ s_i·clip(u_i - mid·s_i, ±ONE).
  - If g > (d-2)·ONE then lo=mid, else hi=mid.
  - k increments each cycle; after BISECT_ITERS cycles, go to FINAL.
- FINAL: result_i = clip(u_i - hi·s_i, ±ONE); go to OUT.
- Output conversion: shift the result left by (DATA_WIDTH-1-IN_FRACTION_WIDTH), then saturate to ±(2^(DATA_WIDTH-1)-1).
- OUT:
  - valid_out=1; tag_out and data_out are held stable until ready_in is high.
  - On output transfer, go to IDLE.
  - valid_in is ignored while in OUT.
- Latency from input-transfer edge to valid_out high:
  - 3 cycles when the box projection is feasible.
  - 4+BISECT_ITERS cycles when bisection runs.
- Throughput: one transaction in flight at a time. There is no overlap with the next accept; ready_out returns the cycle after the output transfer.

Decomposition:
- Shared package holds: ONE, the sum-width and β-width constants, the clog2 function, the FSM state enumeration, and the lane pack/unpack helpers.
- Natural sub-module: centered_clip_sum. It is combinational. Inputs are u, s, β and the active mask; outputs are the clipped vector and Σ s·clip. It is instantiated once and shared by the TEST, BISECT and FINAL states.

Test Plan (DATA_WIDTH=8, IN_FRACTION_WIDTH=6, MAX_DEGREE=4, BISECT_ITERS=8):
1. Feasible, even parity: d=3, u=(0,0,0). s becomes (+,-,-) after the flip at lane 0; g=0 ≤ 64 → data_out=(0,0,0,0), valid_out 3 cycles after accept.
2. Infeasible: d=3, u=(64,64,64). Box gives g=192 > 64, so bisection runs. Outputs lanes 0..2 are equal, each in [40,44] (≈1/3·128), lane 3 = 0; valid_out 12 cycles after accept.
3. Saturation and tie-break: d=2, u=(127,127). Box gives (64,64); the even-parity flip hits lane 0; g=0 ≤ 0 → data_out lanes 0,1 = 127, lanes 2,3 = 0.
4. Backpressure: run scenario 1 with ready_in low for 5 cycles in OUT. valid_out, tag_out and data_out stay stable; ready_out=0 and busy=1. Pulses on valid_in are not captured. ready_in high → ready_out=1 next cycle.
5. Reset mid-operation: pull reset low during BISECT of scenario 2. valid_out, busy and ready_out are 0 while reset is low; ready_out goes to 1 one edge after release. A following scenario 1 completes correctly with its own tag.
6. Degree masking and clamping:
   - d=3 with lane 3 = 127 gives the same output as scenario 1.
   - degree_in=0 behaves as d=2.
   - degree_in=7 behaves as d=4.

Source files
------------

// File: rtl/centered_project_parity_polytope_bisect_pkg.sv
// rtl/centered_project_parity_polytope_bisect_pkg.sv - shared constants, FSM states and lane helpers
package centered_project_parity_polytope_bisect_pkg;

    localparam int DEF_TAG_WIDTH         = 32;
    localparam int DEF_MAX_DEGREE        = 8;
    localparam int DEF_DATA_WIDTH        = 8;
    localparam int DEF_IN_FRACTION_WIDTH = 6;
    localparam int DEF_BISECT_ITERS      = 8;

    function automatic int f_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int f_one(input int frac);
        return 1 << frac;
    endfunction

    function automatic int f_sum_width(input int dw, input int md);
        return dw + f_clog2(md) + 2;
    endfunction

    function automatic int f_beta_width(input int dw);
        return dw + 1;
    endfunction

    function automatic int f_lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIGN,
        ST_TEST,
        ST_BISECT,
        ST_FINAL,
        ST_OUT
    } state_t;

endpackage

// File: rtl/centered_project_parity_polytope_bisect_if.sv
// rtl/centered_project_parity_polytope_bisect_if.sv - input/output handshake bundle of the projector
interface centered_project_parity_polytope_bisect_if
    import centered_project_parity_polytope_bisect_pkg::*;
#(
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int MAX_DEGREE = DEF_MAX_DEGREE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    localparam int DEG_W = f_clog2(MAX_DEGREE + 1);

    logic                             ready_in;
    logic                             valid_in;
    logic [TAG_WIDTH-1:0]             tag_in;
    logic [DEG_W-1:0]                 degree_in;
    logic [DATA_WIDTH*MAX_DEGREE-1:0] data_in;
    logic                             busy;
    logic                             ready_out;
    logic                             valid_out;
    logic [TAG_WIDTH-1:0]             tag_out;
    logic [DATA_WIDTH*MAX_DEGREE-1:0] data_out;

    modport master (
        output ready_in, valid_in, tag_in, degree_in, data_in,
        input  busy, ready_out, valid_out, tag_out, data_out
    );

    modport slave (
        input  ready_in, valid_in, tag_in, degree_in, data_in,
        output busy, ready_out, valid_out, tag_out, data_out
    );

endinterface

// File: rtl/centered_project_parity_polytope_bisect_clip_sum.sv
// rtl/centered_project_parity_polytope_bisect_clip_sum.sv - shifted box clip of every lane and signed sum
module centered_clip_sum
    import centered_project_parity_polytope_bisect_pkg::*;
#(
    parameter int MAX_DEGREE        = DEF_MAX_DEGREE,
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int IN_FRACTION_WIDTH = DEF_IN_FRACTION_WIDTH,
    parameter int SUM_W             = f_sum_width(DATA_WIDTH, MAX_DEGREE),
    parameter int BETA_W            = f_beta_width(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH*MAX_DEGREE-1:0] i_u,
    input  logic [MAX_DEGREE-1:0]            i_s,
    input  logic [BETA_W-1:0]                i_beta,
    input  logic [MAX_DEGREE-1:0]            i_mask,
    output logic [DATA_WIDTH*MAX_DEGREE-1:0] o_clip,
    output logic signed [SUM_W-1:0]          o_sum
);
    localparam logic signed [SUM_W-1:0] ONE_S  = SUM_W'(f_one(IN_FRACTION_WIDTH));
    localparam logic signed [SUM_W-1:0] NONE_S = -ONE_S;

    logic signed [SUM_W-1:0] w_term [MAX_DEGREE];

    // i_s[i]=1 means s_i=+1; each lane computes clip(u_i - beta*s_i) and its s-weighted term
    for (genvar i = 0; i < MAX_DEGREE; i++) begin : g_lane
        logic [DATA_WIDTH-1:0]   w_raw;
        logic signed [SUM_W-1:0] w_u, w_b, w_d, w_c;
        assign w_raw = i_u[f_lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
        assign w_u   = signed'({{(SUM_W-DATA_WIDTH){w_raw[DATA_WIDTH-1]}}, w_raw});
        assign w_b   = signed'({{(SUM_W-BETA_W){1'b0}}, i_beta});
        assign w_d   = i_s[i] ? (w_u - w_b) : (w_u + w_b);
        assign w_c   = (w_d > ONE_S) ? ONE_S : ((w_d < NONE_S) ? NONE_S : w_d);
        assign o_clip[f_lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = i_mask[i] ? w_c[DATA_WIDTH-1:0] : '0;
        assign w_term[i] = !i_mask[i] ? '0 : (i_s[i] ? w_c : -w_c);
    end

    always_comb begin
        o_sum = '0;
        for (int i = 0; i < MAX_DEGREE; i++) o_sum = o_sum + w_term[i];
    end

endmodule

// File: rtl/centered_project_parity_polytope_bisect.sv
// rtl/centered_project_parity_polytope_bisect.sv - iterative parity-polytope projection with bisection on beta
module centered_project_parity_polytope_bisect
    import centered_project_parity_polytope_bisect_pkg::*;
#(
    parameter int TAG_WIDTH         = DEF_TAG_WIDTH,
    parameter int MAX_DEGREE        = DEF_MAX_DEGREE,
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int IN_FRACTION_WIDTH = DEF_IN_FRACTION_WIDTH,
    parameter int BISECT_ITERS      = DEF_BISECT_ITERS
) (
    input logic clk,
    input logic reset,
    centered_project_parity_polytope_bisect_if.slave bus
);
    localparam int DW     = DATA_WIDTH;
    localparam int LW     = DATA_WIDTH * MAX_DEGREE;
    localparam int DEG_W  = f_clog2(MAX_DEGREE + 1);
    localparam int SUM_W  = f_sum_width(DATA_WIDTH, MAX_DEGREE);
    localparam int BETA_W = f_beta_width(DATA_WIDTH);
    localparam int K_W    = f_clog2(BISECT_ITERS + 1);
    localparam int ONE    = f_one(IN_FRACTION_WIDTH);
    localparam int SHIFT  = DATA_WIDTH - 1 - IN_FRACTION_WIDTH;

    localparam logic signed [SUM_W-1:0] ONE_S  = SUM_W'(ONE);
    localparam logic signed [SUM_W-1:0] NONE_S = -ONE_S;
    localparam logic signed [SUM_W-1:0] SAT_S  = SUM_W'((1 << (DW - 1)) - 1);
    localparam logic signed [SUM_W-1:0] NSAT_S = -SAT_S;
    localparam logic [DW-1:0]           SAT_D  = SAT_S[DW-1:0];
    localparam logic [DW-1:0]           NSAT_D = NSAT_S[DW-1:0];
    localparam logic [DW-1:0]           ONE_D  = ONE_S[DW-1:0];
    localparam logic [BETA_W-1:0]       TWO_ONE = BETA_W'(2 * ONE);

    state_t                  r_state, w_next;
    logic                    r_ready_out;
    logic [TAG_WIDTH-1:0]    r_tag;
    logic [DEG_W-1:0]        r_d, w_d_clamped, w_min_idx;
    logic [LW-1:0]           r_u, r_data, w_clip, w_conv;
    logic [MAX_DEGREE-1:0]   r_s, w_s_raw, w_s_sign, w_mask;
    logic [BETA_W-1:0]       r_lo, r_hi, w_mid, w_beta;
    logic [BETA_W:0]         w_mid_sum;
    logic [K_W-1:0]          r_k;
    logic signed [SUM_W-1:0] w_sum, w_thr;
    logic [DW-1:0]           w_abs [MAX_DEGREE];
    logic [DW-1:0]           w_min_val;
    logic                    w_gt, w_in_xfer;

    assign w_in_xfer = bus.valid_in && r_ready_out;
    assign w_mid_sum = {1'b0, r_lo} + {1'b0, r_hi};
    assign w_mid     = BETA_W'(w_mid_sum >> 1);
    assign w_thr     = signed'((SUM_W'(r_d) - SUM_W'(2)) << IN_FRACTION_WIDTH);
    assign w_gt      = (w_sum > w_thr);

    always_comb begin
        w_d_clamped = bus.degree_in;
        if (bus.degree_in < DEG_W'(2))               w_d_clamped = DEG_W'(2);
        else if (bus.degree_in > DEG_W'(MAX_DEGREE)) w_d_clamped = DEG_W'(MAX_DEGREE);
    end

    for (genvar i = 0; i < MAX_DEGREE; i++) begin : g_lane
        logic [DW-1:0]           w_raw, w_cl;
        logic signed [SUM_W-1:0] w_ue, w_mag, w_ce, w_sh;
        assign w_raw      = r_u[f_lane_lsb(i, DW) +: DW];
        assign w_ue       = signed'({{(SUM_W-DW){w_raw[DW-1]}}, w_raw});
        assign w_mask[i]  = (r_d > DEG_W'(i));
        assign w_s_raw[i] = w_mask[i] && !w_ue[SUM_W-1] && (w_ue != '0);
        assign w_mag      = w_ue[SUM_W-1] ? -w_ue : w_ue;
        assign w_abs[i]   = (w_mag > ONE_S) ? ONE_D : w_mag[DW-1:0];
        // clipped lanes sit in [-ONE,ONE]; rescale to DW-1 fraction bits and saturate +ONE
        assign w_cl = w_clip[f_lane_lsb(i, DW) +: DW];
        assign w_ce = signed'({{(SUM_W-DW){w_cl[DW-1]}}, w_cl});
        assign w_sh = w_ce <<< SHIFT;
        assign w_conv[f_lane_lsb(i, DW) +: DW] =
            (w_sh > SAT_S) ? SAT_D : ((w_sh < NSAT_S) ? NSAT_D : w_sh[DW-1:0]);
    end

    // even count of +1 signs: flip the lane closest to zero (lowest index on ties)
    always_comb begin
        w_min_val = '1;
        w_min_idx = '0;
        for (int i = 0; i < MAX_DEGREE; i++) begin
            if (w_mask[i] && (w_abs[i] < w_min_val)) begin
                w_min_val = w_abs[i];
                w_min_idx = DEG_W'(i);
            end
        end
        w_s_sign = w_s_raw;
        if (!(^w_s_raw)) w_s_sign[w_min_idx] = ~w_s_raw[w_min_idx];
    end

    centered_clip_sum #(
        .MAX_DEGREE(MAX_DEGREE), .DATA_WIDTH(DATA_WIDTH), .IN_FRACTION_WIDTH(IN_FRACTION_WIDTH),
        .SUM_W(SUM_W), .BETA_W(BETA_W)
    ) u_clip_sum (
        .i_u(r_u), .i_s(r_s), .i_beta(w_beta), .i_mask(w_mask),
        .o_clip(w_clip), .o_sum(w_sum)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ready_out <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ready_out <= (w_next == ST_IDLE);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_in_xfer) w_next = ST_SIGN;
            ST_SIGN:   w_next = ST_TEST;
            ST_TEST:   w_next = w_gt ? ST_BISECT : ST_OUT;
            ST_BISECT: if (r_k == K_W'(BISECT_ITERS - 1)) w_next = ST_FINAL;
            ST_FINAL:  w_next = ST_OUT;
            ST_OUT:    if (bus.ready_in) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_beta        = '0;
        bus.valid_out = (r_state == ST_OUT);
        bus.busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_BISECT: w_beta = w_mid;
            ST_FINAL:  w_beta = r_hi;
            default:   w_beta = '0;
        endcase
    end

    assign bus.ready_out = r_ready_out;
    assign bus.tag_out   = r_tag;
    assign bus.data_out  = r_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_u    <= '0;
            r_d    <= '0;
            r_tag  <= '0;
            r_s    <= '0;
            r_lo   <= '0;
            r_hi   <= '0;
            r_k    <= '0;
            r_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_in_xfer) begin
                    r_u   <= bus.data_in;
                    r_d   <= w_d_clamped;
                    r_tag <= bus.tag_in;
                end
                ST_SIGN: r_s <= w_s_sign;
                ST_TEST: begin
                    if (w_gt) begin
                        r_lo <= '0;
                        r_hi <= TWO_ONE;
                        r_k  <= '0;
                    end else begin
                        r_data <= w_conv;
                    end
                end
                ST_BISECT: begin
                    if (w_gt) r_lo <= w_mid;
                    else      r_hi <= w_mid;
                    r_k <= r_k + K_W'(1);
                end
                ST_FINAL: r_data <= w_conv;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_centered_project_parity_polytope_bisect.sv
// tb/tb_centered_project_parity_polytope_bisect.sv - directed and randomized checks against a behavioural projector model
module tb_centered_project_parity_polytope_bisect;
    localparam int TW  = 32;
    localparam int MD  = 4;
    localparam int DW  = 8;
    localparam int FW  = 6;
    localparam int IT  = 8;
    localparam int ONE = 64;
    localparam int LW  = MD * DW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    centered_project_parity_polytope_bisect_if #(.TAG_WIDTH(TW), .MAX_DEGREE(MD), .DATA_WIDTH(DW)) bus ();

    centered_project_parity_polytope_bisect #(
        .TAG_WIDTH(TW), .MAX_DEGREE(MD), .DATA_WIDTH(DW), .IN_FRACTION_WIDTH(FW), .BISECT_ITERS(IT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clip1(input int v);
        return (v > ONE) ? ONE : ((v < -ONE) ? -ONE : v);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sgn_sum(input int d, input int u[MD], input int s[MD], input int beta);
        int g;
        g = 0;
        for (int i = 0; i < d; i++) g += s[i] * clip1(u[i] - beta * s[i]);
        return g;
    endfunction

    // result lanes are in DW-1 fraction bits; lat counts the accept edge as cycle 1
    task automatic model(input int deg, input int u[MD], output int res[MD], output int lat);
        int d, m, pos, lo, hi, mid, thr, r;
        int s[MD];
        d   = (deg < 2) ? 2 : ((deg > MD) ? MD : deg);
        thr = (d - 2) * ONE;
        m   = 0;
        pos = 0;
        for (int i = 0; i < d; i++) begin
            s[i] = (clip1(u[i]) > 0) ? 1 : -1;
            if (s[i] > 0) pos++;
            if (iabs(clip1(u[i])) < iabs(clip1(u[m]))) m = i;
        end
        if (pos % 2 == 0) s[m] = -s[m];
        hi  = 0;
        lat = 3;
        if (sgn_sum(d, u, s, 0) > thr) begin
            lo  = 0;
            hi  = 2 * ONE;
            lat = 4 + IT;
            for (int k = 0; k < IT; k++) begin
                mid = (lo + hi) / 2;
                if (sgn_sum(d, u, s, mid) > thr) lo = mid;
                else hi = mid;
            end
        end
        for (int i = 0; i < MD; i++) begin
            if (i < d) begin
                r = clip1(u[i] - hi * s[i]) * (1 << (DW - 1 - FW));
                res[i] = (r > 127) ? 127 : ((r < -127) ? -127 : r);
            end else begin
                res[i] = 0;
            end
        end
    endtask

    function automatic logic [LW-1:0] pack(input int u[MD]);
        logic [LW-1:0] p;
        for (int i = 0; i < MD; i++) p[i*DW +: DW] = u[i][DW-1:0];
        return p;
    endfunction

    task automatic run_txn(input string name, input logic [TW-1:0] tag, input int deg,
                           input int u[MD], input int stall);
        int expv[MD];
        int lat, cyc, wn;
        logic [LW-1:0] exp_bus;
        model(deg, u, expv, lat);
        exp_bus = pack(expv);
        @(negedge clk);
        bus.valid_in  = 1'b1;
        bus.tag_in    = tag;
        bus.degree_in = 3'(deg);
        bus.data_in   = pack(u);
        wn = 0;
        while (!bus.ready_out && wn < 20) begin
            @(negedge clk);
            wn++;
        end
        chk({name, "_accept"}, bus.ready_out, 1);
        if (!bus.ready_out) begin
            bus.valid_in = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.valid_in  = 1'b0;
        bus.tag_in    = $urandom;
        bus.degree_in = 3'($urandom);
        bus.data_in   = LW'($urandom);
        cyc = 1;
        while (cyc < 40) begin
            @(negedge clk);
            if (bus.valid_out) break;
            @(posedge clk);
            cyc++;
        end
        chk({name, "_latency"}, cyc, lat);
        if (!bus.valid_out) return;
        for (int i = 0; i < MD; i++)
            chk($sformatf("%s_lane%0d", name, i), $signed(bus.data_out[i*DW +: DW]), expv[i]);
        chk({name, "_tag"}, bus.tag_out, tag);
        chk({name, "_busy"}, bus.busy, 1);
        chk({name, "_ready_out"}, bus.ready_out, 0);
        for (int c = 0; c < stall; c++) begin
            bus.valid_in = ((c % 2) == 0);
            bus.tag_in   = ~tag;
            @(negedge clk);
            chk({name, "_hold_valid"}, bus.valid_out, 1);
            chk({name, "_hold_data"}, bus.data_out, exp_bus);
            chk({name, "_hold_tag"}, bus.tag_out, tag);
            chk({name, "_hold_ready_out"}, bus.ready_out, 0);
            chk({name, "_hold_busy"}, bus.busy, 1);
        end
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_in = 1'b0;
        @(negedge clk);
        chk({name, "_post_ready_out"}, bus.ready_out, 1);
        chk({name, "_post_valid"}, bus.valid_out, 0);
        chk({name, "_post_busy"}, bus.busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int u[MD];
        int wn;
        bus.ready_in  = 1'b0;
        bus.valid_in  = 1'b0;
        bus.tag_in    = '0;
        bus.degree_in = '0;
        bus.data_in   = '0;
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_ready_out", bus.ready_out, 0);
        chk("rst_tag", bus.tag_out, 0);
        chk("rst_data", bus.data_out, 0);
        reset = 1'b1;
        #1 chk("rel_ready_before_edge", bus.ready_out, 0);
        @(posedge clk);
        #1 chk("rel_ready_after_edge", bus.ready_out, 1);

        u = '{0, 0, 0, 0};        run_txn("s1", 32'h0000_0011, 3, u, 0);
        u = '{64, 64, 64, 0};     run_txn("s2", 32'h0000_0022, 3, u, 0);
        u = '{127, 127, 0, 0};    run_txn("s3", 32'h0000_0033, 2, u, 0);
        u = '{127, 127, -50, 90}; run_txn("s3m", 32'h0000_0034, 2, u, 0);
        u = '{0, 0, 0, 0};        run_txn("s4", 32'h0000_0044, 3, u, 5);

        // abort a bisection with reset, then prove the next transaction is clean
        u = '{64, 64, 64, 0};
        @(negedge clk);
        bus.valid_in  = 1'b1;
        bus.tag_in    = 32'hdead_beef;
        bus.degree_in = 3'd3;
        bus.data_in   = pack(u);
        wn = 0;
        while (!bus.ready_out && wn < 20) begin
            @(negedge clk);
            wn++;
        end
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("s5_busy_before", bus.busy, 1);
        #1 reset = 1'b0;
        #1;
        chk("s5_rst_valid", bus.valid_out, 0);
        chk("s5_rst_busy", bus.busy, 0);
        chk("s5_rst_ready_out", bus.ready_out, 0);
        @(posedge clk);
        #1;
        chk("s5_rst_hold_valid", bus.valid_out, 0);
        chk("s5_rst_hold_ready_out", bus.ready_out, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("s5_rel_ready_before_edge", bus.ready_out, 0);
        @(posedge clk);
        #1;
        chk("s5_rel_ready_after_edge", bus.ready_out, 1);
        chk("s5_rel_busy", bus.busy, 0);
        u = '{0, 0, 0, 0};         run_txn("s5_next", 32'h0000_0055, 3, u, 0);

        u = '{0, 0, 0, 127};       run_txn("s6_mask", 32'h0000_0066, 3, u, 0);
        u = '{100, -20, 30, 5};    run_txn("s6_deg0", 32'h0000_0067, 0, u, 0);
        u = '{100, -20, 30, 5};    run_txn("s6_deg2", 32'h0000_0068, 2, u, 0);
        u = '{40, 50, 60, -70};    run_txn("s6_deg7", 32'h0000_0069, 7, u, 0);
        u = '{40, 50, 60, -70};    run_txn("s6_deg4", 32'h0000_006a, 4, u, 0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < MD; i++) begin
                if ($urandom_range(0, 3) == 0) u[i] = $urandom_range(0, 40) - 20;
                else u[i] = $urandom_range(0, 255) - 128;
            end
            run_txn($sformatf("rnd%0d", n), $urandom, $urandom_range(0, 7), u, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
